// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 set-2 scan decoder feeding a show-ahead character FIFO.
// Optional typematic repeat suppression is enabled by defining TYPEMATIC_FILTER_EN.
module ps2_scan_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       scan_code,
    input  logic             scan_valid,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic             shift_on,
    output logic             caps_on,
    output logic             overflow,
    input  logic             overflow_clr
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t         state;
    logic           shift_l;
    logic           shift_r;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CNT_W-1:0] count;

    logic           is_prefix;
    logic           data_byte;
    logic           brk;
    logic           ext;
    logic           suppress;
    logic [8:0]     glyph;
    logic           push;
    logic           pop;
    logic           full;
    logic           push_ok;

`ifdef TYPEMATIC_FILTER_EN
    logic           last_vld;
    logic [7:0]     last_code;
`endif

    // Returns {valid, ascii}; letters honour upper, everything else honours shift only.
    function automatic logic [8:0] map_code(input logic [7:0] code, input logic shift,
                                            input logic upper);
        logic [7:0] lc;
        lc = 8'h00;
        map_code = 9'h000;
        case (code)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            default: lc = 8'h00;
        endcase
        if (lc != 8'h00) begin
            map_code = {1'b1, upper ? (lc - 8'h20) : lc};
        end else begin
            case (code)
                8'h16: map_code = {1'b1, shift ? "!" : "1"};
                8'h1E: map_code = {1'b1, shift ? "@" : "2"};
                8'h26: map_code = {1'b1, shift ? "#" : "3"};
                8'h25: map_code = {1'b1, shift ? "$" : "4"};
                8'h2E: map_code = {1'b1, shift ? "%" : "5"};
                8'h36: map_code = {1'b1, shift ? "^" : "6"};
                8'h3D: map_code = {1'b1, shift ? "&" : "7"};
                8'h3E: map_code = {1'b1, shift ? "*" : "8"};
                8'h46: map_code = {1'b1, shift ? "(" : "9"};
                8'h45: map_code = {1'b1, shift ? ")" : "0"};
                8'h0E: map_code = {1'b1, shift ? 8'h7E : 8'h60};
                8'h4E: map_code = {1'b1, shift ? "_" : "-"};
                8'h55: map_code = {1'b1, shift ? "+" : "="};
                8'h54: map_code = {1'b1, shift ? 8'h7B : 8'h5B};
                8'h5B: map_code = {1'b1, shift ? 8'h7D : 8'h5D};
                8'h5D: map_code = {1'b1, shift ? 8'h7C : 8'h5C};
                8'h4C: map_code = {1'b1, shift ? 8'h3A : 8'h3B};
                8'h52: map_code = {1'b1, shift ? 8'h22 : 8'h27};
                8'h41: map_code = {1'b1, shift ? 8'h3C : 8'h2C};
                8'h49: map_code = {1'b1, shift ? 8'h3E : 8'h2E};
                8'h4A: map_code = {1'b1, shift ? 8'h3F : 8'h2F};
                8'h29: map_code = 9'h120;
                8'h5A: map_code = 9'h10A;
                8'h66: map_code = 9'h108;
                8'h0D: map_code = 9'h109;
                default: map_code = 9'h000;
            endcase
        end
    endfunction

    function automatic logic [8:0] map_ext(input logic [7:0] code);
        case (code)
            8'h5A:   map_ext = 9'h10A;
            8'h4A:   map_ext = 9'h12F;
            default: map_ext = 9'h000;
        endcase
    endfunction

    assign shift_on   = shift_l | shift_r;
    assign char_valid = (count != '0);
    assign char_out   = char_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;

    always_comb begin
        is_prefix = ((state == IDLE) && ((scan_code == 8'hF0) || (scan_code == 8'hE0)))
                 || ((state == EXT) && (scan_code == 8'hF0));
        data_byte = scan_valid && !is_prefix;
        brk       = (state == BRK) || (state == EXT_BRK);
        ext       = (state == EXT) || (state == EXT_BRK);
        glyph     = ext ? map_ext(scan_code) : map_code(scan_code, shift_on, shift_on ^ caps_on);
        suppress  = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
        suppress  = !ext && last_vld && (last_code == scan_code);
`endif
        push      = data_byte && !brk && glyph[8] && !suppress;
        pop       = char_valid && char_ready;
        full      = (count == CNT_W'(FIFO_DEPTH));
        push_ok   = push && (!full || pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            caps_on <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
            last_vld  <= 1'b0;
            last_code <= 8'h00;
`endif
        end else if (scan_valid) begin
            if (!data_byte) begin
                state <= (scan_code == 8'hE0) ? EXT : ((state == EXT) ? EXT_BRK : BRK);
            end else begin
                state <= IDLE;
                // Extended codes never touch modifiers: E0 12 / E0 59 are fake shifts.
                if (!ext) begin
                    if (brk) begin
                        if (scan_code == 8'h12) shift_l <= 1'b0;
                        if (scan_code == 8'h59) shift_r <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
                        if (last_vld && (last_code == scan_code)) last_vld <= 1'b0;
`endif
                    end else begin
                        case (scan_code)
                            8'h12:   shift_l <= 1'b1;
                            8'h59:   shift_r <= 1'b1;
                            8'h58:   caps_on <= ~caps_on;
                            default: begin
`ifdef TYPEMATIC_FILTER_EN
                                last_vld  <= 1'b1;
                                last_code <= scan_code;
`endif
                            end
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= glyph[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
            else if (overflow_clr)    overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb/tb_ps2_scan_decoder.sv - scoreboard bench for ps2_scan_decoder with a keyboard-level model.
module tb_ps2_scan_decoder;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    scan_code = 8'h00;
    logic          scan_valid = 1'b0;
    logic [7:0]    char_out;
    logic          char_valid;
    logic          char_ready = 1'b1;
    logic [CW-1:0] fifo_count;
    logic          shift_on;
    logic          caps_on;
    logic          overflow;
    logic          overflow_clr = 1'b0;

    ps2_scan_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
        .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
        .fifo_count(fifo_count), .shift_on(shift_on), .caps_on(caps_on),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    bit exp_ovf = 0;

    // Keyboard model: prefix flags, modifier flags and lookup tables.
    bit m_brk = 0, m_ext = 0, m_ls = 0, m_rs = 0, m_caps = 0, m_last_v = 0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
        8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
        8'h46, 8'h45};
    logic [7:0] punct_codes [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
        8'h41, 8'h49, 8'h4A};
    logic [7:0] digit_lo [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
        8'h39, 8'h30};
    logic [7:0] digit_hi [10] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A,
        8'h28, 8'h29};
    logic [7:0] punct_lo [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
        8'h2C, 8'h2E, 8'h2F};
    logic [7:0] punct_hi [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
        8'h3C, 8'h3E, 8'h3F};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_brk = 0; m_ext = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_last_v = 0; m_last = 8'h00;
    endfunction

    function automatic void lookup(input logic [7:0] b, output bit has, output logic [7:0] ch);
        bit sh;
        sh = m_ls | m_rs;
        has = 1; ch = 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == b) begin
                ch = ((sh ^ m_caps) ? 8'h41 : 8'h61) + 8'(i);
                return;
            end
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == b) begin
                ch = sh ? digit_hi[i] : digit_lo[i];
                return;
            end
        for (int i = 0; i < 11; i++)
            if (punct_codes[i] == b) begin
                ch = sh ? punct_hi[i] : punct_lo[i];
                return;
            end
        case (b)
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0A;
            8'h66: ch = 8'h08;
            8'h0D: ch = 8'h09;
            default: has = 0;
        endcase
    endfunction

    function automatic void model_byte(input logic [7:0] b, output bit has, output logic [7:0] ch);
        bit was_brk, was_ext;
        has = 0; ch = 8'h00;
        if (!m_brk && !m_ext && (b == 8'hF0)) begin m_brk = 1; return; end
        if (!m_brk && !m_ext && (b == 8'hE0)) begin m_ext = 1; return; end
        if (m_ext && !m_brk && (b == 8'hF0)) begin m_brk = 1; return; end
        was_brk = m_brk; was_ext = m_ext;
        m_brk = 0; m_ext = 0;
        if (was_ext) begin
            if (!was_brk && b == 8'h5A) begin has = 1; ch = 8'h0A; end
            if (!was_brk && b == 8'h4A) begin has = 1; ch = 8'h2F; end
            return;
        end
        if (was_brk) begin
            if (b == 8'h12) m_ls = 0;
            if (b == 8'h59) m_rs = 0;
            if (m_last_v && m_last == b) m_last_v = 0;
            return;
        end
        if (b == 8'h12) begin m_ls = 1; return; end
        if (b == 8'h59) begin m_rs = 1; return; end
        if (b == 8'h58) begin m_caps = !m_caps; return; end
`ifdef TYPEMATIC_FILTER_EN
        if (m_last_v && m_last == b) return;
        m_last_v = 1; m_last = b;
`endif
        lookup(b, has, ch);
    endfunction

    // Called at posedge+1; a character is dropped only if the FIFO is full and no pop is due.
    task automatic send(input logic [7:0] b);
        bit has;
        logic [7:0] ch;
        scan_code = b;
        scan_valid = 1'b1;
        model_byte(b, has, ch);
        if (has) begin
            if (exp_q.size() >= DEPTH && !char_ready) exp_ovf = 1;
            else exp_q.push_back(ch);
        end
        @(posedge clk); #1;
        scan_valid = 1'b0;
        chk("shift_on", int'(shift_on), int'(m_ls | m_rs));
        chk("caps_on", int'(caps_on), int'(m_caps));
        chk("overflow", int'(overflow), int'(exp_ovf));
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        char_ready = 1'b1;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("drain_left", exp_q.size(), 0);
        chk("count_after_drain", int'(fifo_count), 0);
    endtask

    // Monitor: a handshake is due at the next posedge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && char_valid && char_ready) begin
            if (exp_q.size() == 0) chk("unexpected_char", int'(char_out), 256);
            else chk("char_out", int'(char_out), int'(exp_q.pop_front()));
        end
    end

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 8)  return 8'hF0;
        if (r < 12) return 8'hE0;
        if (r < 18) begin
            r = $urandom_range(0, 2);
            return (r == 0) ? 8'h12 : (r == 1) ? 8'h59 : 8'h58;
        end
        if (r < 50) return letter_codes[$urandom_range(0, 25)];
        if (r < 62) return digit_codes[$urandom_range(0, 9)];
        if (r < 72) return punct_codes[$urandom_range(0, 10)];
        if (r < 80) begin
            r = $urandom_range(0, 3);
            return (r == 0) ? 8'h29 : (r == 1) ? 8'h5A : (r == 2) ? 8'h66 : 8'h0D;
        end
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1;
        chk("reset_valid", int'(char_valid), 0);
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_char", int'(char_out), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send(8'h1C); send(8'hF0); send(8'h1C);
        wait_drain();
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        wait_drain();
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); send(8'h16);
        send(8'h12); send(8'h16); send(8'hF0); send(8'h12);
        send(8'h58);
        wait_drain();
        send(8'hE0); send(8'h12); send(8'h1C);
        send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A); send(8'h07);
        send(8'hE0); send(8'h4A); send(8'h4A); send(8'h5D); send(8'h0D);
        wait_drain();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        wait_drain();

        char_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(8'h29); send(8'hF0); send(8'h29);
        end
        chk("full_count", int'(fifo_count), DEPTH);
        chk("full_overflow", int'(overflow), 1);
        wait_drain();
        chk("overflow_sticky", int'(overflow), 1);
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        exp_ovf = 0;
        chk("overflow_clr", int'(overflow), 0);

        char_ready = 1'b0;
        send(8'h12);
        for (int i = 0; i < 3; i++) begin
            send(8'h1C); send(8'hF0); send(8'h1C);
        end
        send(8'hE0);
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.delete();
        exp_ovf = 0;
        chk("rst_char_out", int'(char_out), 0);
        chk("rst_char_valid", int'(char_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_shift", int'(shift_on), 0);
        chk("rst_caps", int'(caps_on), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        char_ready = 1'b1;
        send(8'h1C); send(8'hF0); send(8'h1C);
        wait_drain();

        for (int blk = 0; blk < 8; blk++) begin
            int bias;
            bias = (blk % 2 == 0) ? 90 : 15;
            for (int i = 0; i < 50; i++) begin
                char_ready = ($urandom_range(0, 99) < bias);
                send(pick_byte());
            end
        end
        wait_drain();
        chk("final_overflow", int'(overflow), int'(exp_ovf));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Sequential successor to the combinational scan-code-to-glyph lookup.
- Consumes raw PS/2 set-2 scan bytes from the keyboard receiver. Tracks break (F0) and extended (E0) prefixes, Shift state and Caps Lock.
- Emits 8-bit ASCII characters through a parametrised show-ahead FIFO with valid/ready handshake, toward the VGA text writer.

Parameters:
- FIFO_DEPTH, 8, character FIFO entries; power of two, 2..64.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scan_code  in  8  scan byte from PS/2 receiver
- scan_valid  in  1  one-cycle strobe, scan_code valid
- char_out  out  8  ASCII at FIFO head
- char_valid  out  1  FIFO not empty
- char_ready  in  1  consumer accepts char_out this cycle
- fifo_count  out  CNT_W  current occupancy
- shift_on  out  1  left or right Shift held
- caps_on  out  1  Caps Lock latched
- overflow  out  1  sticky: a character was dropped because FIFO was full
- overflow_clr  in  1  clears overflow

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, FIFO empty, char_out=0, char_valid=0, fifo_count=0, shift_on=0, caps_on=0, overflow=0. Reset mid-sequence discards any pending prefix.
- FSM advances only on scan_valid=1. States: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: F0->BRK; E0->EXT; other byte = make code, processed, stay IDLE.
  - BRK: byte = break code, processed, ->IDLE.
  - EXT: F0->EXT_BRK; other byte = extended make, ->IDLE.
  - EXT_BRK: extended break, ->IDLE.
  - E0 or F0 received in BRK/EXT_BRK: treated as data, ->IDLE.
- Modifiers:
  - Make 12 or 59 sets the corresponding shift bit; break clears it. shift_on = OR of both bits.
  - Make 58 toggles caps_on; break 58 has no effect.
  - Extended 12/59 (fake shift) are ignored.
- Character map, unshifted/shifted:
  - Letters 1C..1A: a-z / A-Z; uppercase when shift_on XOR caps_on.
  - Digits 16,1E,26,25,2E,36,3D,3E,46,45: "1234567890" / "!@#$%^&*()".
  - 0E `/~, 4E -/_, 55 =/+, 54 [/{, 5B ]/}, 5D \/|, 4C ;/:, 52 '/", 41 ,/<, 49 ./>, 4A //?.
  - Punctuation and digits follow shift_on only; Caps Lock does not affect them.
  - 29 -> 0x20, 5A -> 0x0A, 66 -> 0x08, 0D -> 0x09.
  - Extended: E0 5A -> 0x0A, E0 4A -> '/'.
  - All other make codes, all break codes and all other extended codes produce no character. There is no default glyph.
- Latency: a printable make sampled at cycle N is written at edge N+1. char_valid=1 from cycle N+1 if the FIFO was empty.
- FIFO:
  - Pop when char_valid & char_ready.
  - Push when full and no pop: character dropped, overflow<=1.
  - Push when full with simultaneous pop: push accepted, count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count is exact at every cycle.
- overflow: overflow_clr=1 clears it; a set event in the same cycle wins.
- Modifier updates take effect at the edge following the sampled byte. A letter in the next scan event uses the new state.

Optional Feature:
- Macro TYPEMATIC_FILTER_EN.
- Defined: a register holds the last accepted non-modifier make code. A repeated make of the same code with no intervening break of that code pushes nothing. The register is cleared by that key's break and by reset.
- Undefined: every typematic repeat pushes a character.

Test Plan:
- Bytes 1C, F0 1C, char_ready=1 -> exactly one char 0x61 ('a'); char_valid high one cycle.
- 12, 1C, F0 12, 1C -> 0x41 then 0x61; shift_on 1 then 0.
- 58, F0 58, 1C, 16 -> caps_on=1, chars 0x41, 0x31; then 12, 16 -> 0x21.
- char_ready=0, FIFO_DEPTH+1 presses of 29 -> fifo_count=FIFO_DEPTH, overflow=1. Drain -> all 0x20. Pulse overflow_clr -> overflow=0.
- E0 12, 1C -> 0x61 (shift unaffected); E0 5A -> 0x0A; E0 F0 5A -> nothing; 07 -> nothing.
- Assert rst_n=0 after E0 mid-stream with 3 queued chars -> all outputs zero. After release, 1C -> 0x61. With TYPEMATIC_FILTER_EN: 1C,1C,1C,F0 1C -> single 0x61.
